// File: rtl/joust2_rom_loader_if.sv
// HPS ioctl download stream plus downstream ROM-store write port.
// The loader sits on the slave side and the environment on the master side.
interface joust2_rom_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        rom_we;
    logic [1:0]  rom_sel;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ack;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
        input  ioctl_wait, rom_we, rom_sel, rom_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
        output ioctl_wait, rom_we, rom_sel, rom_addr, rom_data
    );
endinterface

// File: rtl/joust2_rom_loader.sv
// Routes the index-0 HPS ROM download into CPU/sound/graphics regions, checks
// the downloaded length and holds the williams2 core in reset until it is complete.
module joust2_rom_loader #(
    parameter logic [17:0] EXP_LEN  = 18'h2C000,
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    joust2_rom_loader_if.slave      bus,
    output logic                    core_reset_n,
    output logic                    load_done,
    output logic                    load_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;
    logic        ovf_q, ovf_d;
    logic        viol_q, viol_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic        wait_q, wait_d;
    logic [1:0]  sel_q, sel_d;
    logic [16:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        core_q, core_d;

    logic        map_in_s;
    logic [1:0]  map_sel_s;
    logic [16:0] map_addr_s;
    logic        idx0_s;
    logic        enter_hold_s;
    logic [17:0] cnt_inc_s;

    assign bus.ioctl_wait = wait_q;
    assign bus.rom_we     = we_q;
    assign bus.rom_sel    = sel_q;
    assign bus.rom_addr   = addr_q;
    assign bus.rom_data   = data_q;
    assign core_reset_n   = core_q;
    assign load_done      = done_q;
    assign load_err       = err_q;

    assign idx0_s    = (bus.ioctl_index == 8'h00);
    assign cnt_inc_s = (cnt_q == 18'h3FFFF) ? cnt_q : (cnt_q + 18'd1);

    // Decode the download byte address into a ROM region and region offset.
    always_comb begin
        map_in_s   = 1'b0;
        map_sel_s  = 2'd0;
        map_addr_s = 17'd0;
        if (bus.ioctl_addr < 25'h18000) begin
            map_in_s   = 1'b1;
            map_sel_s  = 2'd0;
            map_addr_s = bus.ioctl_addr[16:0];
        end else if (bus.ioctl_addr < 25'h20000) begin
            map_in_s   = 1'b1;
            map_sel_s  = 2'd1;
            map_addr_s = 17'(bus.ioctl_addr - 25'h18000);
        end else if (bus.ioctl_addr < 25'h2C000) begin
            map_in_s   = 1'b1;
            map_sel_s  = 2'd2;
            map_addr_s = 17'(bus.ioctl_addr - 25'h20000);
        end else begin
            map_in_s   = 1'b0;
        end
    end

    // Loader FSM next-state and registered-output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        ovf_d        = ovf_q;
        viol_d       = viol_q;
        done_d       = done_q;
        err_d        = err_q;
        we_d         = we_q;
        wait_d       = wait_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        data_d       = data_q;
        enter_hold_s = 1'b0;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (bus.ioctl_download && idx0_s) begin
                    state_d = S_LOAD;
                    cnt_d   = 18'd0;
                    ovf_d   = 1'b0;
                    viol_d  = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (!bus.ioctl_download) begin
                    state_d      = S_HOLD;
                    enter_hold_s = 1'b1;
                end else if (bus.ioctl_wr && idx0_s) begin
                    if (map_in_s) begin
                        sel_d   = map_sel_s;
                        addr_d  = map_addr_s;
                        data_d  = bus.ioctl_dout;
                        we_d    = 1'b1;
                        wait_d  = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        ovf_d   = 1'b1;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WRITE: begin
                // A strobe here is a protocol violation; the pending write is kept.
                if (bus.ioctl_wr && idx0_s) begin
                    viol_d = 1'b1;
                end else begin
                    viol_d = viol_q;
                end
                if (bus.rom_ack) begin
                    we_d   = 1'b0;
                    wait_d = 1'b0;
                    cnt_d  = cnt_inc_s;
                    if (bus.ioctl_download) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d      = S_HOLD;
                        enter_hold_s = 1'b1;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_HOLD: begin
                if (({16'd0, hold_q} + 32'd1) >= 32'(HOLD_CYC)) begin
                    state_d = S_RUN;
                end else begin
                    hold_d  = hold_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The entry clock counts as the first hold cycle.
        if (enter_hold_s) begin
            hold_d = 16'd1;
            if ((cnt_d == EXP_LEN) && !ovf_d && !viol_d) begin
                done_d = 1'b1;
            end else begin
                err_d  = 1'b1;
            end
        end else begin
            hold_d = hold_d;
        end

        core_d = (state_d == S_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 18'd0;
            hold_q  <= 16'd0;
            ovf_q   <= 1'b0;
            viol_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wait_q  <= 1'b0;
            sel_q   <= 2'd0;
            addr_q  <= 17'd0;
            data_q  <= 8'd0;
            core_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
            viol_q  <= viol_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            wait_q  <= wait_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            core_q  <= core_d;
        end
    end

endmodule

// File: doc/joust2_rom_loader.md
JOUST2_ROM_LOADER -- requirements
Module: joust2_rom_loader

Interface
REQ-001 Parameter EXP_LEN, default 18'h2C000, expected total ROM byte count for a complete download.
REQ-002 Parameter HOLD_CYC, default 16, core reset hold length in clocks after download end.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  high while the HPS streams ROM data.
REQ-006 ioctl_index  in  8  download slot; only 8'h00 is ROM data.
REQ-007 ioctl_wr  in  1  one-cycle strobe, byte valid on ioctl_addr/ioctl_dout.
REQ-008 ioctl_addr  in  25  byte address of the strobed byte.
REQ-009 ioctl_dout  in  8  strobed data byte.
REQ-010 ioctl_wait  out  1  backpressure to the HPS; high stalls the next strobe.
REQ-011 rom_we  out  1  write request to the downstream ROM store; held until rom_ack.
REQ-012 rom_sel  out  2  target region: 0 CPU, 1 sound, 2 graphics.
REQ-013 rom_addr  out  17  region-relative byte address.
REQ-014 rom_data  out  8  byte to write.
REQ-015 rom_ack  in  1  downstream accepts the write in the cycle it is high with rom_we.
REQ-016 core_reset_n  out  1  active-low reset to the williams2 core.
REQ-017 load_done  out  1  sticky: last download complete and correct length.
REQ-018 load_err  out  1  sticky: last download short, long, or protocol violation.

Function
REQ-019 Address map (index 0): 0x00000-0x17FFF -> sel 0, addr = ioctl_addr; 0x18000-0x1FFFF -> sel 1, addr = ioctl_addr-0x18000; 0x20000-0x2BFFF -> sel 2, addr = ioctl_addr-0x20000; >=0x2C000 -> not written, sets overflow.
REQ-020 FSM states: IDLE, LOAD, WRITE, HOLD, RUN.
REQ-021 IDLE -> LOAD when ioctl_download=1 and ioctl_index=0; clears byte counter, overflow, load_done, load_err.
REQ-022 LOAD: ioctl_wr with in-range address latches sel/addr/data, asserts rom_we and ioctl_wait next cycle, -> WRITE.
REQ-023 LOAD: ioctl_wr with out-of-range address sets overflow, no write, stays LOAD, ioctl_wait stays low.
REQ-024 WRITE: rom_we, rom_sel, rom_addr, rom_data stable until rom_ack; on rom_ack: rom_we and ioctl_wait low next cycle, byte counter +1, -> LOAD.
REQ-025 Single-cycle ack: ioctl_wait high exactly one cycle per accepted byte when rom_ack is high the first cycle of WRITE.
REQ-026 ioctl_wr while in WRITE is a protocol violation: byte dropped, violation flag set, current write unaffected.
REQ-027 ioctl_download falling in LOAD -> HOLD; falling in WRITE completes the pending write first, then -> HOLD.
REQ-028 On HOLD entry: load_done=1 iff counter==EXP_LEN and no overflow or violation; otherwise load_err=1.
REQ-029 HOLD counts HOLD_CYC clocks, then -> RUN; core_reset_n low in IDLE, LOAD, WRITE, HOLD, high only in RUN.
REQ-030 RUN -> LOAD when ioctl_download=1 with index 0 (reload); counters/flags cleared as in REQ-021.
REQ-031 Downloads with ioctl_index!=0 ignored in all states: no writes, no wait, no state change.
REQ-032 Byte counter 18 bits, saturates at 18'h3FFFF, never wraps.

Reset
REQ-033 reset_n low: state IDLE; ioctl_wait, rom_we, core_reset_n, load_done, load_err = 0; rom_sel, rom_addr, rom_data = 0; counters and flags = 0.
REQ-034 reset_n asserted mid-WRITE aborts the write immediately; no rom_ack is awaited after release.

Verification
REQ-035 Full 0x2C000-byte index-0 download, rom_ack tied high -> 0x2C000 rom_we pulses; byte 0x18005 -> sel 1 addr 0x00005; load_done=1; core_reset_n high 16 clocks after download falls.
REQ-036 rom_ack delayed 3 cycles on byte 0x20010 -> ioctl_wait high 4 cycles, rom_data/rom_addr (0x00010, sel 2) stable throughout, counter +1 only once.
REQ-037 Download of 0x2BFFF bytes -> load_err=1, load_done=0, core_reset_n still released after HOLD.
REQ-038 Byte at 0x2C000 included -> no rom_we for it, load_err=1.
REQ-039 Extra ioctl_wr during WRITE -> load_err=1, only the first byte written.
REQ-040 reset_n pulsed low while in WRITE -> all outputs 0 within the same cycle, state IDLE, next download starts clean.
